// File: rtl/lsu_mem_stage_if.sv
// EXU-side instruction bus, SRAM request/response bus and WBU result bus of the load/store stage.
// The stage itself takes the slave modport; the driving environment takes the master modport.
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_load;
    logic            in_is_store;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_misalign;
    logic            out_fault;

    modport slave (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output out_valid, out_result, out_misalign, out_fault,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  out_valid, out_result, out_misalign, out_fault,
        output out_ready
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage in front of the data SRAM; min latency 3 cycles accept->out_valid (1 for pass-through/misaligned).
// One instruction in flight: in_ready only in IDLE; request held until mem_req_ready, result held until out_ready.
module lsu_mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    lsu_mem_stage_if.slave  bus
);
    localparam int  CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit  TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            live_q;
    logic            st_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [XLEN-1:0] res_q, res_d;
    logic            mis_q, mis_d;
    logic            flt_q, flt_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            mem_op;
    logic            bad_acc;
    logic [CW-1:0]   cnt_inc;
    logic            to_hit;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_val;
    logic [3:0]      strb_base;

    assign accept  = bus.in_valid && bus.in_ready;
    assign mem_op  = bus.in_is_load || bus.in_is_store;
    assign cnt_inc = cnt_q + 1'b1;
    assign to_hit  = TO_EN && (cnt_inc == CW'(TIMEOUT));

    // Illegal width encodings and unaligned H/W accesses never reach the SRAM.
    always_comb begin
        bad_acc = 1'b0;
        case (bus.in_funct3)
            3'b000:         bad_acc = 1'b0;
            3'b001:         bad_acc = bus.in_addr[0];
            3'b010:         bad_acc = (bus.in_addr[1:0] != 2'b00);
            3'b100:         bad_acc = bus.in_is_store;
            3'b101:         bad_acc = bus.in_is_store || bus.in_addr[0];
            default:        bad_acc = 1'b1;
        endcase
    end

    always_comb begin
        ld_shift = bus.mem_resp_data >> {addr_q[1:0], 3'b000};
        ld_val   = ld_shift;
        case (f3_q)
            3'b000:  ld_val = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        mis_d   = mis_q;
        flt_d   = flt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    mis_d = 1'b0;
                    flt_d = 1'b0;
                    res_d = bus.in_addr;
                    if (!mem_op) begin
                        state_d = DONE;
                    end else if (bad_acc) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (to_hit) begin
                    flt_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end else if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // A response on the limit cycle still completes normally.
                if (bus.mem_resp_valid) begin
                    res_d   = st_q ? '0 : ld_val;
                    state_d = DONE;
                end else if (to_hit) begin
                    flt_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            mis_q   <= 1'b0;
            flt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            res_q   <= res_d;
            mis_q   <= mis_d;
            flt_q   <= flt_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                st_q    <= bus.in_is_store;
                f3_q    <= bus.in_funct3;
                addr_q  <= bus.in_addr;
                wdata_q <= bus.in_wdata;
            end
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   strb_base = 4'b0001;
            2'b01:   strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    // live_q keeps in_ready low while reset is held and until the first edge after release.
    assign bus.in_ready      = live_q && (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_addr      = (state_q == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign bus.mem_wen       = (state_q == REQ) && st_q;
    assign bus.mem_wstrb     = ((state_q == REQ) && st_q) ? (strb_base << addr_q[1:0]) : 4'b0000;
    assign bus.mem_wdata     = ((state_q == REQ) && st_q) ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_result    = (state_q == DONE) ? res_q : '0;
    assign bus.out_misalign  = (state_q == DONE) && mis_q;
    assign bus.out_fault     = (state_q == DONE) && flt_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with TIMEOUT=8; expected values are hand-computed constants.
module tb_lsu_mem_stage;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    lsu_mem_stage_if #(.XLEN(32)) bus ();

    lsu_mem_stage #(.XLEN(32), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction and return just after its acceptance edge.
    task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.in_is_load  = ld;
        bus.in_is_store = st;
        bus.in_funct3   = f3;
        bus.in_addr     = a;
        bus.in_wdata    = wd;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Full memory op with an immediate grant and the response one cycle after the request.
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] resp,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic e_wen, input logic [31:0] e_res);
        send(ld, st, f3, a, wd);
        check({tag, "_req_vld"}, {31'd0, bus.mem_req_valid}, 32'd1);
        check({tag, "_addr"},    bus.mem_addr, e_addr);
        check({tag, "_wstrb"},   {28'd0, bus.mem_wstrb}, {28'd0, e_strb});
        check({tag, "_wdata"},   bus.mem_wdata, e_wdata);
        check({tag, "_wen"},     {31'd0, bus.mem_wen}, {31'd0, e_wen});
        tick();
        check({tag, "_no_out_in_wait"}, {31'd0, bus.out_valid}, 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = resp;
        tick();
        bus.mem_resp_valid = 1'b0;
        check({tag, "_out_vld"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_result"},  bus.out_result, e_res);
        check({tag, "_flags"},   {30'd0, bus.out_misalign, bus.out_fault}, 32'd0);
        tick();
    endtask

    // Instruction that completes without touching memory.
    task automatic direct(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic e_mis);
        send(ld, st, f3, a, 32'hFFFF_FFFF);
        check({tag, "_out_vld"},  {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_result"},   bus.out_result, a);
        check({tag, "_misalign"}, {31'd0, bus.out_misalign}, {31'd0, e_mis});
        check({tag, "_no_req"},   {31'd0, bus.mem_req_valid}, 32'd0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid       = 1'b0;
        bus.in_is_load     = 1'b0;
        bus.in_is_store    = 1'b0;
        bus.in_funct3      = 3'b000;
        bus.in_addr        = '0;
        bus.in_wdata       = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.out_ready      = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_outputs", {29'd0, bus.mem_req_valid, bus.out_valid, bus.out_fault}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_release_ready_low", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("rst_ready_after_clk", {31'd0, bus.in_ready}, 32'd1);

        direct("pass", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 1'b0);

        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_BBCC,
               32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80AA_BBCC,
               32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_0080);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80AA_BBCC,
               32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_80AA);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80AA_BBCC,
               32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_80AA);
        mem_op("lb0", 1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h80AA_BB4C,
               32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_004C);
        mem_op("lw",  1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h80AA_BBCC,
               32'h8000_0008, 4'b0000, 32'h0, 1'b0, 32'h80AA_BBCC);
        mem_op("sh",  1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555,
               32'h8000_0000, 4'b1100, 32'hABCD_0000, 1'b1, 32'h0);
        mem_op("sb",  1'b0, 1'b1, 3'b000, 32'h8000_0011, 32'h1234_ABCD, 32'h0,
               32'h8000_0010, 4'b0010, 32'h34AB_CD00, 1'b1, 32'h0);
        mem_op("ldst", 1'b1, 1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h1111_1111,
               32'h8000_0004, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0);

        direct("mis_lw",   1'b1, 1'b0, 3'b010, 32'h8000_0001, 1'b1);
        direct("bad_f3",   1'b1, 1'b0, 3'b011, 32'h8000_0000, 1'b1);
        direct("mis_lh",   1'b1, 1'b0, 3'b001, 32'h8000_0003, 1'b1);
        direct("st_bu",    1'b0, 1'b1, 3'b100, 32'h8000_0000, 1'b1);

        // Grant withheld for 3 cycles: request must not move.
        bus.mem_req_ready = 1'b0;
        send(1'b0, 1'b1, 3'b001, 32'h8000_0022, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("bp_req_vld",  {31'd0, bus.mem_req_valid}, 32'd1);
            check("bp_req_addr", bus.mem_addr, 32'h8000_0020);
            check("bp_req_data", bus.mem_wdata, 32'hBEEF_0000);
            check("bp_req_strb", {28'd0, bus.mem_wstrb}, 32'h0000_000C);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        check("bp_req_dropped", {31'd0, bus.mem_req_valid}, 32'd0);
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("bp_req_done", {31'd0, bus.out_valid}, 32'd1);
        tick();

        // WBU stalls for 4 cycles: result held, no new instruction accepted.
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 3'b000, 32'h0000_ABCD, 32'h0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_out_result", bus.out_result, 32'h0000_ABCD);
            check("bp_out_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_out_released", {31'd0, bus.out_valid}, 32'd0);
        check("bp_out_idle", {31'd0, bus.in_ready}, 32'd1);

        // No response: fault after 8 cycles in REQ/WAIT.
        send(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("to_not_yet", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("to_out_vld", {31'd0, bus.out_valid}, 32'd1);
        check("to_fault", {31'd0, bus.out_fault}, 32'd1);
        check("to_result", bus.out_result, 32'h0);
        check("to_req_off", {31'd0, bus.mem_req_valid}, 32'd0);
        tick();

        // Response on the 8th cycle wins over the timeout.
        send(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("to_race_vld", {31'd0, bus.out_valid}, 32'd1);
        check("to_race_fault", {31'd0, bus.out_fault}, 32'd0);
        check("to_race_result", bus.out_result, 32'hDEAD_BEEF);
        tick();

        // Reset while waiting for the response.
        send(1'b1, 1'b0, 3'b010, 32'h8000_0080, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_wait_req", {31'd0, bus.mem_req_valid}, 32'd0);
        check("rst_wait_addr", bus.mem_addr, 32'h0);
        check("rst_wait_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_wait_out", {31'd0, bus.out_valid}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_wait_idle", {31'd0, bus.in_ready}, 32'd1);
        check("rst_wait_no_retry", {31'd0, bus.mem_req_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
